// File: rtl/serial_arbiter.sv
// serial_arbiter: round-robin packet arbiter muxing N requesters onto one UART byte stream
//   clk, rst                     clock and synchronous active-high reset
//   req_valid/req_data/req_last  per-requester byte stream (lane i at [i*W +: W])
//   req_ready                    per-requester accept (owner only)
//   tx_valid/tx_data/tx_ready    byte stream toward the UART transmitter
//   grant, busy, timeout         current owner, locked flag, forced-release pulse
module serial_arbiter #(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_valid,
   input  logic [N*W-1:0]       req_data,
   input  logic [N-1:0]         req_last,
   output logic [N-1:0]         req_ready,
   output logic                 tx_valid,
   output logic [W-1:0]         tx_data,
   input  logic                 tx_ready,
   output logic [$clog2(N)-1:0] grant,
   output logic                 busy,
   output logic                 timeout
);
   localparam int GW = $clog2(N);
   localparam int SW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state_q, state_d;
   logic [GW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick;
   logic [SW-1:0] stall_q, stall_d;
   logic xfer, stalled;
   // descending scan so the requester closest after ptr is written last and wins
   always_comb begin
      logic [GW:0] idx;
      idx  = '0;
      pick = '0;
      for (int k = N; k >= 1; k--) begin
         idx = {1'b0, ptr_q} + (GW+1)'(k);
         if (idx >= (GW+1)'(N)) idx = idx - (GW+1)'(N);
         if (req_valid[idx[GW-1:0]]) pick = idx[GW-1:0];
      end
   end
   assign busy    = state_q == LOCKED;
   assign grant   = grant_q;
   assign tx_data = req_data[grant_q*W +: W];
   assign xfer    = busy && req_valid[grant_q] && tx_ready;
   assign stalled = busy && !req_valid[grant_q];
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      stall_d   = stall_q;
      timeout   = 1'b0;
      tx_valid  = 1'b0;
      req_ready = '0;
      if (!busy) begin
         stall_d = '0;
         if (|req_valid) begin
            state_d = LOCKED;
            grant_d = pick;
         end
      end else begin
         tx_valid           = req_valid[grant_q];
         req_ready[grant_q] = tx_ready;
         stall_d = xfer ? '0 : stalled ? stall_q + SW'(stall_q != '1) : stall_q;
         if (xfer && req_last[grant_q]) begin
            state_d = IDLE;
            ptr_d   = grant_q;
         end else if (stalled && stall_q == STALL_MAX) begin
            state_d = IDLE;
            ptr_d   = grant_q;
            timeout = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= GW'(N - 1);
         grant_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         stall_q <= stall_d;
      end
   end
endmodule

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, data width in bits.
REQ-003 Parameter TIMEOUT, default 1024, idle cycles tolerated mid-packet before forced release (>=2).
REQ-004 clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  N  per-requester data valid.
REQ-007 req_data  input  N*W  per-requester data; requester i occupies bits [i*W +: W].
REQ-008 req_last  input  N  per-requester end-of-packet flag, qualified by req_valid.
REQ-009 req_ready  output  N  per-requester accept.
REQ-010 tx_valid  output  1  byte valid toward the UART transmitter.
REQ-011 tx_data  output  W  byte toward the UART transmitter.
REQ-012 tx_ready  input  1  UART transmitter accept.
REQ-013 grant  output  $clog2(N)  index of the current owner; meaningful only while busy=1.
REQ-014 busy  output  1  high while the arbiter is in the LOCKED state.
REQ-015 timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-016 The arbiter SHALL implement a two-state FSM with states IDLE and LOCKED.
REQ-017 IDLE: the arbiter SHALL drive tx_valid=0 and req_ready=0.
REQ-018 IDLE: when any req_valid is high, the arbiter SHALL register grant, move to LOCKED on the next edge, and search round-robin starting at (ptr+1) mod N.
REQ-019 LOCKED, combinational pass-through from owner g: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready; all other req_ready=0.
REQ-020 A transfer SHALL occur when tx_valid and tx_ready are both high; every beat SHALL be transferred exactly once, in order.
REQ-021 A transfer with req_last[g]=1 SHALL set ptr=g and return the FSM to IDLE on the next edge.
REQ-022 A new grant SHALL NOT be issued in the cycle of the last transfer; the minimum gap between packets is 1 IDLE cycle.
REQ-023 Arbitration latency SHALL be 1 cycle from req_valid rising in IDLE to tx_valid high.
REQ-024 Stall counter, LOCKED only: increments on cycles with req_valid[g]=0; clears on any transfer and on entry to LOCKED.
REQ-025 The stall counter SHALL NOT increment on backpressure (req_valid[g]=1, tx_ready=0).
REQ-026 When the stall counter reaches TIMEOUT-1 while still stalled, the FSM SHALL go to IDLE, set ptr=g, and pulse timeout for 1 cycle.
REQ-027 The stall counter SHALL be $clog2(TIMEOUT+1) bits and SHALL saturate without wrapping.
REQ-028 Requests arriving while LOCKED SHALL wait with no loss; a requester deasserting valid before it is granted SHALL be legal.
REQ-029 Wrap-around: when ptr=N-1, the search SHALL start at 0.
REQ-030 A single requester holding valid continuously SHALL be re-granted after each 1-cycle IDLE gap.

Reset
REQ-031 When rst=1 at a clock edge, the next state SHALL be: FSM=IDLE, ptr=N-1, grant=0, stall counter=0, busy=0, timeout=0, tx_valid=0, req_ready=0.
REQ-032 Reset SHALL override all other events, including reset mid-packet; a partially sent packet SHALL be abandoned and SHALL NOT be resumed.
REQ-033 After reset, requester 0 SHALL have the highest priority.

Verification
REQ-034 Reset, then req_valid=4'b1111 with all packets 2 bytes and tx_ready=1 -> grants in order 0,1,2,3,0; bytes of a packet contiguous; 1 IDLE cycle between packets.
REQ-035 Requester 2 sends a 3-byte packet A1,A2,A3 with last on A3 while requester 1 is valid throughout -> tx_data sequence A1,A2,A3 uninterrupted; grant moves to 3 if valid, else wraps to 0, then 1.
REQ-036 tx_ready held 0 for 2000 cycles mid-packet -> no timeout pulse, req_ready[g]=0, and the data holds stable on tx_data.
REQ-037 TIMEOUT=16: owner drops valid after byte 1 -> timeout pulse exactly 16 cycles after the last transfer, busy=0 on the next cycle, and the next requester is granted.
REQ-038 rst asserted for 1 cycle mid-packet of requester 3 -> the next cycle shows busy=0 and tx_valid=0; with all requesters valid, the next grant is 0.
REQ-039 N=2, only requester 1 valid with back-to-back single-byte packets and tx_ready=1 -> one byte every 2 cycles, and grant stays 1.
